// File: rtl/md5_pkg.sv
// md5_pkg -- shared definitions for the MD5 message sequencer.
//   md5_state_e   : sequencer FSM state encoding (also exported as a debug port)
//   MD5_*_W       : block, digest, word and byte-counter widths
//   MD5_IV_*      : MD5 initial chaining values (A..D), reloaded by the core
//                   whenever core_first accompanies a block
package md5_pkg;

  localparam int MD5_WORD_W    = 32;
  localparam int MD5_BLOCK_W   = 512;
  localparam int MD5_DIGEST_W  = 128;
  localparam int MD5_BYTE_CNT_W = 61;  // byte count; bit length = count << 3 fits 64 bits

  localparam logic [31:0] MD5_IV_A = 32'h6745_2301;
  localparam logic [31:0] MD5_IV_B = 32'hefcd_ab89;
  localparam logic [31:0] MD5_IV_C = 32'h98ba_dcfe;
  localparam logic [31:0] MD5_IV_D = 32'h1032_5476;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_PAD   = 3'd4,
    S_DONE  = 3'd5
  } md5_state_e;

endpackage

// File: rtl/md5_pad_block.sv
// md5_pad_block -- combinational MD5 padding of one 64-byte block.
//   blk_i      : raw buffered block, byte n at bits [8n+7:8n]
//   offset_i   : byte position of the 0x80 marker (message bytes mod 64)
//   len_en_i   : overwrite words 14/15 with the message bit length
//   bit_len_i  : message length in bits (low half -> word 14, high -> word 15)
//   blk_o      : bytes below offset_i kept, 0x80 at offset_i, zeros above
module md5_pad_block
  import md5_pkg::*;
(
  input  logic [MD5_BLOCK_W-1:0] blk_i,
  input  logic [5:0]             offset_i,
  input  logic                   len_en_i,
  input  logic [63:0]            bit_len_i,
  output logic [MD5_BLOCK_W-1:0] blk_o
);

  always_comb begin
    blk_o = '0;
    for (int b = 0; b < 64; b++) begin
      if (6'(b) < offset_i) begin
        blk_o[8*b +: 8] = blk_i[8*b +: 8];
      end else if (6'(b) == offset_i) begin
        blk_o[8*b +: 8] = 8'h80;
      end
    end
    if (len_en_i) begin
      blk_o[511:448] = bit_len_i;
    end
  end

endmodule

// File: rtl/md5_msg_sequencer.sv
// md5_msg_sequencer -- packs a byte-stream message into padded 512-bit MD5
// blocks, feeds them one at a time to an MD5 core and returns the digest.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; once valid is raised it stays high, with its payload stable,
// until that transfer (in_valid/in_ready, core_block_valid/core_block_ready).
//
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data        : message words, first byte in [7:0]
//   in_last/in_nbytes                : final word marker and its byte count
//   core_block_valid/_ready          : block to core, one outstanding at most
//   core_block/core_first            : block payload, first-of-message flag
//   core_total_length                : message length in bits
//   core_done/core_digest            : core completion pulse and result
//   digest/digest_valid              : latched digest, one-cycle valid pulse
//   busy/timeout_err                 : not idle / sticky core timeout
//   dbg_state                        : current FSM state
//   blocks_issued/msgs_done          : wrapping counters, present only when
//                                      MD5_SEQ_STATS_EN is defined
module md5_msg_sequencer
  import md5_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_data,
  input  logic                    in_last,
  input  logic [2:0]              in_nbytes,
  output logic                    core_block_valid,
  input  logic                    core_block_ready,
  output logic [MD5_BLOCK_W-1:0]  core_block,
  output logic                    core_first,
  output logic [63:0]             core_total_length,
  input  logic                    core_done,
  input  logic [MD5_DIGEST_W-1:0] core_digest,
  output logic [MD5_DIGEST_W-1:0] digest,
  output logic                    digest_valid,
  output logic                    busy,
  output logic                    timeout_err,
`ifdef MD5_SEQ_STATS_EN
  output logic [31:0]             blocks_issued,
  output logic [31:0]             msgs_done,
`endif
  output md5_state_e              dbg_state
);

  md5_state_e                  state_q;
  logic [15:0][31:0]           buf_q;
  logic [3:0]                  wcnt_q;
  logic [MD5_BYTE_CNT_W-1:0]   bytes_q;
  logic                        first_q;   // next issued block starts a message
  logic                        final_q;   // block in flight ends the message
  logic                        mark_q;    // data-only block in flight; marker block follows
  logic                        pad2_q;    // marker block in flight; length-only block follows
  logic [31:0]                 timer_q;
  logic                        timeout_err_q;
  logic [MD5_DIGEST_W-1:0]     digest_q;
`ifdef MD5_SEQ_STATS_EN
  logic [31:0]                 blocks_q;
  logic [31:0]                 msgs_q;
`endif

  logic                        accept;
  logic [2:0]                  nb_eff;
  logic [3:0]                  widx;
  logic [MD5_BYTE_CNT_W-1:0]   bytes_next;
  logic [63:0]                 bit_len;
  logic                        short_tail;
  logic [MD5_BLOCK_W-1:0]      pad_blk;

  assign in_ready   = (state_q == S_IDLE || state_q == S_FILL) && !reset;
  assign accept     = in_valid && in_ready;
  assign nb_eff     = !in_last ? 3'd4 : (in_nbytes > 3'd4 ? 3'd4 : in_nbytes);
  // A new message starts counting from zero at word slot 0.
  assign widx       = (state_q == S_IDLE) ? 4'd0 : wcnt_q;
  assign bytes_next = ((state_q == S_IDLE) ? '0 : bytes_q) + MD5_BYTE_CNT_W'(nb_eff);
  assign bit_len    = {bytes_q, 3'b000};
  // Length fits behind the marker only when the marker lands at byte 55 or below.
  assign short_tail = (bytes_q[5:0] <= 6'd55);

  md5_pad_block u_pad (
    .blk_i     (buf_q),
    .offset_i  (bytes_q[5:0]),
    .len_en_i  (short_tail),
    .bit_len_i (bit_len),
    .blk_o     (pad_blk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      wcnt_q        <= '0;
      bytes_q       <= '0;
      first_q       <= 1'b0;
      final_q       <= 1'b0;
      mark_q        <= 1'b0;
      pad2_q        <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      digest_q      <= '0;
`ifdef MD5_SEQ_STATS_EN
      blocks_q      <= '0;
      msgs_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_FILL: begin
          if (accept) begin
            buf_q[widx] <= in_data;
            bytes_q     <= bytes_next;
            if (state_q == S_IDLE) begin
              first_q <= 1'b1;
              mark_q  <= 1'b0;
              pad2_q  <= 1'b0;
            end
            if (in_last && widx == 4'd15 && nb_eff == 3'd4) begin
              // Message ends exactly on a block boundary: send the data,
              // then a block holding only the marker and length.
              final_q <= 1'b0;
              mark_q  <= 1'b1;
              state_q <= S_ISSUE;
            end else if (in_last) begin
              state_q <= S_PAD;
            end else if (widx == 4'd15) begin
              final_q <= 1'b0;
              state_q <= S_ISSUE;
            end else begin
              wcnt_q  <= widx + 4'd1;
              state_q <= S_FILL;
            end
          end
        end
        S_PAD: begin
          buf_q   <= pad_blk;
          final_q <= short_tail;
          pad2_q  <= !short_tail;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (core_block_ready) begin
            first_q <= 1'b0;
            timer_q <= '0;
            state_q <= S_WAIT;
`ifdef MD5_SEQ_STATS_EN
            blocks_q <= blocks_q + 32'd1;
`endif
          end
        end
        S_WAIT: begin
          if (core_done) begin
            if (final_q) begin
              digest_q <= core_digest;
              state_q  <= S_DONE;
            end else if (mark_q) begin
              // bytes_q mod 64 is 0 here, so padding puts 0x80 at byte 0.
              mark_q  <= 1'b0;
              state_q <= S_PAD;
            end else if (pad2_q) begin
              pad2_q  <= 1'b0;
              final_q <= 1'b1;
              buf_q   <= {bit_len, 448'b0};
              state_q <= S_ISSUE;
            end else begin
              wcnt_q  <= '0;
              state_q <= S_FILL;
            end
          end else if (timer_q == 32'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            final_q       <= 1'b0;
            mark_q        <= 1'b0;
            pad2_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_DONE: begin
`ifdef MD5_SEQ_STATS_EN
          msgs_q  <= msgs_q + 32'd1;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_block_valid  = (state_q == S_ISSUE);
  assign core_block        = buf_q;
  assign core_first        = first_q;
  assign core_total_length = bit_len;
  assign digest            = digest_q;
  assign digest_valid      = (state_q == S_DONE);
  assign busy              = (state_q != S_IDLE);
  assign timeout_err       = timeout_err_q;
  assign dbg_state         = state_q;
`ifdef MD5_SEQ_STATS_EN
  assign blocks_issued     = blocks_q;
  assign msgs_done         = msgs_q;
`endif

endmodule
